// File: rtl/regfile_wb_arb.sv
// Write-back arbiter: grants one of NREQ requesters per cycle onto a registered register-file write port.
// Define REGFILE_WB_RR_EN for round-robin arbitration; otherwise the lowest-index valid requester wins.
module regfile_wb_arb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NREQ   = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     stall,
  output logic                     regwe,
  output logic [ADDR_W-1:0]        writeAddr,
  output logic [DATA_W-1:0]        writeData,
  output logic [15:0]              wr_count
);

  localparam int PTR_W = $clog2(NREQ);

  logic [NREQ-1:0][ADDR_W-1:0] w_addr_a;
  logic [NREQ-1:0][DATA_W-1:0] w_data_a;
  logic [PTR_W-1:0]            w_ptr;
  logic [PTR_W-1:0]            w_gidx;
  logic [PTR_W-1:0]            w_idx;
  logic [PTR_W:0]              w_sum;
  logic                        w_xfer;

  logic                        r_regwe;
  logic [ADDR_W-1:0]           r_waddr;
  logic [DATA_W-1:0]           r_wdata;
  logic [15:0]                 r_cnt;

  assign w_addr_a = req_addr;
  assign w_data_a = req_data;

`ifdef REGFILE_WB_RR_EN
  logic [PTR_W-1:0] r_ptr;
  assign w_ptr = r_ptr;

  // Pointer moves just past the winner, so the winner becomes lowest priority next time.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_ptr <= '0;
    else if (w_xfer)
      r_ptr <= (w_gidx == PTR_W'(NREQ-1)) ? '0 : w_gidx + 1'b1;
  end
`else
  assign w_ptr = '0;
`endif

  // Search upward from the pointer with wrap; first valid requester wins.
  always_comb begin
    w_xfer = 1'b0;
    w_gidx = '0;
    w_sum  = '0;
    w_idx  = '0;
    if (rst_n && !stall) begin
      for (int k = 0; k < NREQ; k++) begin
        w_sum = {1'b0, w_ptr} + (PTR_W+1)'(k);
        if (w_sum >= (PTR_W+1)'(NREQ))
          w_sum = w_sum - (PTR_W+1)'(NREQ);
        w_idx = w_sum[PTR_W-1:0];
        if (!w_xfer && req_valid[w_idx]) begin
          w_xfer = 1'b1;
          w_gidx = w_idx;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (w_xfer)
      req_ready[w_gidx] = 1'b1;
  end

  // Register 0 writes are accepted but never raise regwe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_regwe <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
    end else begin
      r_regwe <= w_xfer && (w_addr_a[w_gidx] != '0);
      if (w_xfer) begin
        r_waddr <= w_addr_a[w_gidx];
        r_wdata <= w_data_a[w_gidx];
      end
      if (r_regwe)
        r_cnt <= r_cnt + 16'd1;
    end
  end

  assign regwe     = r_regwe;
  assign writeAddr = r_waddr;
  assign writeData = r_wdata;
  assign wr_count  = r_cnt;

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Self-checking bench for regfile_wb_arb: directed table, hand sequences, random traffic vs. a reference model.
module tb_regfile_wb_arb;
  localparam int NREQ = 3;
  localparam int AW   = 4;
  localparam int DW   = 32;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 stall = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_addr = '0;
  logic [NREQ*DW-1:0]   req_data = '0;
  logic                 regwe;
  logic [AW-1:0]        writeAddr;
  logic [DW-1:0]        writeData;
  logic [15:0]          wr_count;

  regfile_wb_arb #(.DATA_W(DW), .ADDR_W(AW), .NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .stall(stall), .regwe(regwe),
    .writeAddr(writeAddr), .writeData(writeData), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  int          m_ptr = 0;
  bit          m_we = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  int          m_cnt = 0;
  int          last_g;
  logic [NREQ-1:0] last_ready;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick();
    if (!rst_n || stall) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  // One clock: check the combinational grant, advance the model, check the write port.
  task automatic tick();
    int g;
    logic [NREQ-1:0] er;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    #1;
    g = pick();
    er = (g >= 0) ? (NREQ'(1) << g) : '0;
    chk("ready", req_ready, er);
    last_g = g;
    last_ready = req_ready;
    a = (g >= 0) ? req_addr[g*AW +: AW] : '0;
    d = (g >= 0) ? req_data[g*DW +: DW] : '0;
    @(posedge clk);
    if (!rst_n) begin
      m_ptr = 0; m_we = 0; m_addr = '0; m_data = '0; m_cnt = 0;
    end else begin
      m_cnt = (m_cnt + int'(m_we)) % 65536;
      if (g >= 0) begin
        m_we = (a != '0);
        m_addr = a;
        m_data = d;
`ifdef REGFILE_WB_RR_EN
        m_ptr = (g + 1) % NREQ;
`endif
      end else begin
        m_we = 0;
      end
    end
    #1;
    chk("regwe", regwe, m_we);
    chk("writeAddr", writeAddr, m_addr);
    chk("writeData", writeData, m_data);
    chk("wr_count", wr_count, m_cnt[15:0]);
  endtask

  typedef struct {
    logic [NREQ-1:0] valid;
    logic            stl;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   data;
    logic [NREQ-1:0] e_rdy;
    logic            e_we;
    logic [AW-1:0]   e_addr;
    logic [DW-1:0]   e_data;
    logic [15:0]     e_cnt;
  } vec_t;

  vec_t tbl[13];
  logic [NREQ-1:0] rr_exp[6];
  bit              pend[NREQ];
  logic [AW-1:0]   s_addr[NREQ];
  logic [DW-1:0]   s_data[NREQ];

  initial begin
    tbl[0]  = '{3'b001, 1'b0, 4'd5,  32'hDEADBEEF, 3'b001, 1'b1, 4'd5,  32'hDEADBEEF, 16'd0};
    tbl[1]  = '{3'b000, 1'b0, 4'd0,  32'h0,        3'b000, 1'b0, 4'd5,  32'hDEADBEEF, 16'd1};
    tbl[2]  = '{3'b010, 1'b0, 4'd0,  32'h1234,     3'b010, 1'b0, 4'd0,  32'h1234,     16'd1};
    tbl[3]  = '{3'b000, 1'b0, 4'd0,  32'h0,        3'b000, 1'b0, 4'd0,  32'h1234,     16'd1};
    tbl[4]  = '{3'b100, 1'b1, 4'd7,  32'hA5A5A5A5, 3'b000, 1'b0, 4'd0,  32'h1234,     16'd1};
    tbl[5]  = '{3'b100, 1'b1, 4'd7,  32'hA5A5A5A5, 3'b000, 1'b0, 4'd0,  32'h1234,     16'd1};
    tbl[6]  = '{3'b100, 1'b1, 4'd7,  32'hA5A5A5A5, 3'b000, 1'b0, 4'd0,  32'h1234,     16'd1};
    tbl[7]  = '{3'b100, 1'b1, 4'd7,  32'hA5A5A5A5, 3'b000, 1'b0, 4'd0,  32'h1234,     16'd1};
    tbl[8]  = '{3'b100, 1'b0, 4'd7,  32'hA5A5A5A5, 3'b100, 1'b1, 4'd7,  32'hA5A5A5A5, 16'd1};
    tbl[9]  = '{3'b000, 1'b0, 4'd0,  32'h0,        3'b000, 1'b0, 4'd7,  32'hA5A5A5A5, 16'd2};
    tbl[10] = '{3'b001, 1'b0, 4'd9,  32'h11111111, 3'b001, 1'b1, 4'd9,  32'h11111111, 16'd2};
    tbl[11] = '{3'b010, 1'b0, 4'd10, 32'h22222222, 3'b010, 1'b1, 4'd10, 32'h22222222, 16'd3};
    tbl[12] = '{3'b000, 1'b0, 4'd0,  32'h0,        3'b000, 1'b0, 4'd10, 32'h22222222, 16'd4};
`ifdef REGFILE_WB_RR_EN
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`else
    rr_exp = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`endif

    // Reset with requests present: no grant may leak through.
    rst_n = 1'b0;
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 2), DW'(i) + 32'h100);
    tick();
    chk("rst_ready", last_ready, 3'b000);
    tick();
    chk("rst_regwe", regwe, 1'b0);
    chk("rst_waddr", writeAddr, 4'd0);
    chk("rst_wdata", writeData, 32'd0);
    chk("rst_count", wr_count, 16'd0);
    rst_n = 1'b1;
    req_valid = '0;

    // Directed table
    for (int r = 0; r < 13; r++) begin
      req_valid = tbl[r].valid;
      stall = tbl[r].stl;
      for (int i = 0; i < NREQ; i++)
        if (tbl[r].valid[i]) set_req(i, tbl[r].addr, tbl[r].data);
        else set_req(i, tbl[r].addr ^ 4'hF, ~tbl[r].data);
      tick();
      chk($sformatf("tbl%0d_ready", r), last_ready, tbl[r].e_rdy);
      chk($sformatf("tbl%0d_regwe", r), regwe, tbl[r].e_we);
      chk($sformatf("tbl%0d_waddr", r), writeAddr, tbl[r].e_addr);
      chk($sformatf("tbl%0d_wdata", r), writeData, tbl[r].e_data);
      chk($sformatf("tbl%0d_count", r), wr_count, tbl[r].e_cnt);
    end
    stall = 1'b0;

    // All requesters continuously valid from reset
    rst_n = 1'b0; req_valid = '0; tick();
    rst_n = 1'b1;
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 1), 32'hC0DE0000 + DW'(i));
    for (int c = 0; c < 6; c++) begin
      tick();
      chk($sformatf("arb%0d", c), last_ready, rr_exp[c]);
    end
    req_valid = '0;

    // Reset lands on the commit cycle of a write to register 3
    req_valid = 3'b001; set_req(0, 4'd3, 32'h33333333);
    tick();
    req_valid = '0;
    chk("mid_pre_we", regwe, 1'b1);
    rst_n = 1'b0;
    tick();
    chk("mid_we", regwe, 1'b0);
    chk("mid_count", wr_count, 16'd0);
    rst_n = 1'b1;
    req_valid = '1;
    tick();
    chk("mid_ptr", last_ready, 3'b001);
    req_valid = '0;
    tick();

    // Random traffic with hold-until-accepted requesters
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    for (int c = 0; c < 400; c++) begin
      stall = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 49) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i]) begin
          chk("hold_addr", req_addr[i*AW +: AW], s_addr[i]);
          chk("hold_data", req_data[i*DW +: DW], s_data[i]);
        end else if ($urandom_range(0, 1) == 1) begin
          pend[i] = 1;
          s_addr[i] = AW'($urandom_range(0, 15));
          s_data[i] = $urandom;
          set_req(i, s_addr[i], s_data[i]);
        end
        req_valid[i] = pend[i];
      end
      tick();
      if (last_g >= 0) pend[last_g] = 0;
    end
    req_valid = '0; stall = 1'b0; rst_n = 1'b1;
    tick();

    // Counter wrap: 65535 writes then one more
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    req_valid = 3'b001;
    set_req(0, 4'd1, 32'h0BADF00D);
    repeat (65535) tick();
    req_valid = '0;
    tick(); tick();
    chk("wrap_ffff", wr_count, 16'hFFFF);
    req_valid = 3'b001;
    tick();
    req_valid = '0;
    tick(); tick();
    chk("wrap_zero", wr_count, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arb.md
REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, write-data width.
REQ-002 The block SHALL have parameter ADDR_W, default 4, register address width (16 registers).
REQ-003 The block SHALL have parameter NREQ, default 3, number of write-back requesters; legal range 2..8.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-006 The block SHALL have port req_valid, input, NREQ, per-requester write request.
REQ-007 The block SHALL have port req_addr, input, NREQ*ADDR_W, packed destination addresses; requester i at slice [i*ADDR_W +: ADDR_W].
REQ-008 The block SHALL have port req_data, input, NREQ*DATA_W, packed write data; requester i at slice [i*DATA_W +: DATA_W].
REQ-009 The block SHALL have port req_ready, output, NREQ, one-hot or zero grant/accept, combinational.
REQ-010 The block SHALL have port stall, input, 1, blocks all grants while high.
REQ-011 The block SHALL have ports regwe (output, 1), writeAddr (output, ADDR_W) and writeData (output, DATA_W), the registered register-file write port.
REQ-012 The block SHALL have port wr_count, output, 16, count of writes committed to the register file.

Function
REQ-013 A transfer on requester i SHALL occur in a cycle where req_valid[i] and req_ready[i] are both high.
REQ-014 Requesters SHALL hold req_valid, addr and data stable until accepted; the bench SHALL flag any violation.
REQ-015 At most one req_ready bit SHALL be high per cycle; req_ready SHALL be all-zero when stall=1 or rst_n=0.
REQ-016 The grant SHALL be made to the first valid requester at or after priority pointer ptr, searching upward with wrap from NREQ-1 to 0.
REQ-017 After a transfer by requester g, ptr SHALL become (g+1) mod NREQ; without a transfer, ptr SHALL be unchanged.
REQ-018 A transfer in cycle N SHALL drive writeAddr and writeData in cycle N+1, with fixed latency 1.
REQ-019 regwe SHALL be high in cycle N+1 only if the transferred address is nonzero; register 0 writes are accepted and dropped.
REQ-020 With no transfer in cycle N, regwe SHALL be 0 in N+1 and writeAddr/writeData SHALL hold their previous values.
REQ-021 wr_count SHALL increment by 1 in the cycle after each regwe=1 pulse is committed, wrapping 0xFFFF to 0x0000.
REQ-022 When stall rises, pending requests SHALL wait; no request SHALL be dropped, and ptr SHALL be frozen.
REQ-023 Back-to-back transfers SHALL sustain one write per cycle.

Reset
REQ-024 When rst_n=0 at a clock edge, the block SHALL set ptr=0, regwe=0, writeAddr=0, writeData=0 and wr_count=0.
REQ-025 A transfer in the cycle rst_n is low SHALL NOT occur, because req_ready is forced to 0.
REQ-026 A write captured before reset SHALL be discarded if reset falls on its commit cycle.

Configuration
REQ-027 The block SHALL honour macro REGFILE_WB_RR_EN.
REQ-028 With REGFILE_WB_RR_EN defined, the block SHALL arbitrate round-robin per REQ-016/REQ-017.
REQ-029 Without REGFILE_WB_RR_EN, the block SHALL use fixed priority: lowest-index valid requester wins, and ptr is absent or held at 0.

Verification
REQ-030 Single write: req0 addr=5, data=0xDEADBEEF -> req_ready[0] in same cycle; next cycle regwe=1, writeAddr=5, writeData=0xDEADBEEF; wr_count=1.
REQ-031 Round-robin, RR_EN on, NREQ=3: all three valid continuously from reset -> grants 0,1,2,0,1,2; without RR_EN -> grants 0 while req0 is held.
REQ-032 Zero address: req1 addr=0, data=0x1234 -> req_ready[1]=1; next cycle regwe=0; wr_count unchanged.
REQ-033 Stall: req2 valid addr=7 with stall=1 for 4 cycles -> req_ready=0 throughout; on stall=0, grant next cycle and regwe=1, writeAddr=7 one cycle later.
REQ-034 Reset mid-stream: rst_n=0 in the commit cycle of a write to addr 3 -> regwe=0, wr_count=0, ptr=0 afterward.
REQ-035 Counter wrap: preload via 65535 writes, then one more -> wr_count=0x0000.
